// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the two-master SRAM-like request arbiter:
// command bundle layout, data width and master IDs.
package sram_req_arbiter_pkg;

  localparam int unsigned CMD_W     = 71;
  localparam int unsigned DATA_W    = 32;

  // Bit offsets (LSB) of each field inside the command bundle
  localparam int unsigned CMD_WR    = 70;
  localparam int unsigned CMD_SIZE  = 68;
  localparam int unsigned CMD_WSTRB = 64;
  localparam int unsigned CMD_ADDR  = 32;
  localparam int unsigned CMD_WDATA = 0;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of 1-bit master IDs for accepted-but-unanswered requests.
// A push is visible at the head on the cycle after it is written.
module sram_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  import sram_req_arbiter_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    do_push  = push & ~full;
    do_pop   = pop & ~empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges instruction-fetch (m0) and data (m1) SRAM-like ports onto one memory port,
// routing each in-order response back to the master that issued the request.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned CMD_W       = sram_req_arbiter_pkg::CMD_W
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   m0_req,
  input  logic [CMD_W-1:0]                       m0_cmd,
  output logic                                   m0_addr_ok,
  output logic                                   m0_data_ok,
  output logic [sram_req_arbiter_pkg::DATA_W-1:0] m0_rdata,
  input  logic                                   m1_req,
  input  logic [CMD_W-1:0]                       m1_cmd,
  output logic                                   m1_addr_ok,
  output logic                                   m1_data_ok,
  output logic [sram_req_arbiter_pkg::DATA_W-1:0] m1_rdata,
  output logic                                   s_req,
  output logic [CMD_W-1:0]                       s_cmd,
  input  logic                                   s_addr_ok,
  input  logic                                   s_data_ok,
  input  logic [sram_req_arbiter_pkg::DATA_W-1:0] s_rdata,
  output logic                                   arb_err
);
  import sram_req_arbiter_pkg::*;

  if ((OUTSTANDING < 2) || ((OUTSTANDING & (OUTSTANDING - 1)) != 0)) begin : g_bad_depth
    $error("sram_req_arbiter: OUTSTANDING must be a power of two >= 2");
  end

  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;
  logic arb_err_q, arb_err_d;
  logic grant, req_sel;
  logic push, pop;
  logic fifo_full, fifo_empty, fifo_head;

  // Grant: a stalled request keeps the bus; otherwise the data port wins
  always_comb begin
    grant   = ID_INST;
    req_sel = m0_req | m1_req;
    if (lock_q) begin
      grant   = lock_id_q;
      req_sel = (lock_id_q == ID_DATA) ? m1_req : m0_req;
    end else if (m1_req) begin
      grant   = ID_DATA;
    end

    s_req      = resetn & req_sel & ~fifo_full;
    s_cmd      = {CMD_W{resetn}} & ((grant == ID_DATA) ? m1_cmd : m0_cmd);
    m0_addr_ok = s_addr_ok & s_req & (grant == ID_INST);
    m1_addr_ok = s_addr_ok & s_req & (grant == ID_DATA);
    push       = s_req & s_addr_ok;

    lock_d     = s_req & ~s_addr_ok;
    lock_id_d  = lock_d ? grant : lock_id_q;
  end

  // Responses follow the FIFO head; a response with nothing in flight is an error
  always_comb begin
    pop        = s_data_ok & ~fifo_empty;
    m0_data_ok = resetn & pop & (fifo_head == ID_INST);
    m1_data_ok = resetn & pop & (fifo_head == ID_DATA);
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    arb_err_d  = arb_err_q | (s_data_ok & fifo_empty);
    arb_err    = arb_err_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_INST;
      arb_err_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      arb_err_q <= arb_err_d;
    end
  end

  sram_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (grant),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: expected response IDs are queued at
// acceptance and checked against data_ok routing when responses are driven.
module tb_sram_req_arbiter;

  localparam int unsigned CMD_W = 71;

  logic             clk = 1'b0;
  logic             resetn;
  logic             m0_req, m1_req;
  logic [CMD_W-1:0] m0_cmd, m1_cmd;
  logic             m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0]      m0_rdata, m1_rdata;
  logic             s_req;
  logic [CMD_W-1:0] s_cmd;
  logic             s_addr_ok, s_data_ok;
  logic [31:0]      s_rdata;
  logic             arb_err;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic err_m;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .OUTSTANDING (4),
    .CMD_W       (CMD_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_req     (m0_req),
    .m0_cmd     (m0_cmd),
    .m0_addr_ok (m0_addr_ok),
    .m0_data_ok (m0_data_ok),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_cmd     (m1_cmd),
    .m1_addr_ok (m1_addr_ok),
    .m1_data_ok (m1_data_ok),
    .m1_rdata   (m1_rdata),
    .s_req      (s_req),
    .s_cmd      (s_cmd),
    .s_addr_ok  (s_addr_ok),
    .s_data_ok  (s_data_ok),
    .s_rdata    (s_rdata),
    .arb_err    (arb_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // acc: -1 no acceptance expected, 0/1 master expected to be accepted this cycle
  task automatic sample(input int acc);
    logic e;
    #2;
    chk("m0_addr_ok", 128'(m0_addr_ok), 128'(acc == 0));
    chk("m1_addr_ok", 128'(m1_addr_ok), 128'(acc == 1));
    chk("arb_err", 128'(arb_err), 128'(err_m));
    chk("m0_rdata", 128'(m0_rdata), 128'(s_rdata));
    chk("m1_rdata", 128'(m1_rdata), 128'(s_rdata));
    if (s_data_ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("m0_data_ok", 128'(m0_data_ok), 128'(e == 1'b0));
      chk("m1_data_ok", 128'(m1_data_ok), 128'(e == 1'b1));
    end else begin
      chk("m0_data_ok_idle", 128'(m0_data_ok), 128'(0));
      chk("m1_data_ok_idle", 128'(m1_data_ok), 128'(0));
      if (s_data_ok) err_m = 1'b1;
    end
    if (acc >= 0) exp_q.push_back(acc[0]);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    err_m     = 1'b0;
    m0_cmd    = {1'b0, 2'd2, 4'hf, 32'h1C00_0000, 32'h0000_0000};
    m1_cmd    = {1'b1, 2'd2, 4'h3, 32'h1C01_0040, 32'hDEAD_BEEF};
    m0_req    = 1'b1; m1_req = 1'b0;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h1234_5678;

    // Outputs held at zero while in reset, rdata passes through
    #3;
    chk("rst_s_req", 128'(s_req), 128'(0));
    chk("rst_s_cmd", 128'(s_cmd), 128'(0));
    chk("rst_m0_addr_ok", 128'(m0_addr_ok), 128'(0));
    chk("rst_m0_data_ok", 128'(m0_data_ok), 128'(0));
    chk("rst_arb_err", 128'(arb_err), 128'(0));
    chk("rst_m0_rdata", 128'(m0_rdata), 128'(32'h1234_5678));
    tick();
    tick();
    idle_inputs();
    resetn = 1'b1;
    sample(-1);
    tick();

    // Single m0 read
    m0_req = 1'b1; s_addr_ok = 1'b1;
    #1 chk("t1_s_req", 128'(s_req), 128'(1));
    chk("t1_s_cmd", 128'(s_cmd), 128'(m0_cmd));
    sample(0);
    tick();
    idle_inputs();
    sample(-1);
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h0280_0000;
    sample(-1);
    chk("t1_rdata", 128'(m0_rdata), 128'(32'h0280_0000));
    tick();

    // Both request, slave stalls 3 cycles: m1 holds the bus, then m0
    idle_inputs();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_s_cmd_stall", 128'(s_cmd), 128'(m1_cmd));
      chk("t2_s_req_stall", 128'(s_req), 128'(1));
      sample(-1);
      tick();
    end
    s_addr_ok = 1'b1;
    #1 chk("t2_s_cmd_acc", 128'(s_cmd), 128'(m1_cmd));
    sample(1);
    tick();
    m1_req = 1'b0;
    #1 chk("t2_s_cmd_m0", 128'(s_cmd), 128'(m0_cmd));
    sample(0);
    tick();
    idle_inputs();
    s_data_ok = 1'b1; s_rdata = 32'hAAAA_0001;
    sample(-1);
    tick();
    s_rdata = 32'hAAAA_0002;
    sample(-1);
    tick();

    // Lock hold: m0 stalled, m1 arrives later and must wait
    idle_inputs();
    m0_req = 1'b1;
    sample(-1);
    tick();
    m1_req = 1'b1;
    #1 chk("t3_s_cmd_locked", 128'(s_cmd), 128'(m0_cmd));
    sample(-1);
    tick();
    s_addr_ok = 1'b1;
    sample(0);
    tick();
    m0_req = 1'b0;
    #1 chk("t3_s_cmd_m1", 128'(s_cmd), 128'(m1_cmd));
    sample(1);
    tick();
    idle_inputs();
    s_data_ok = 1'b1; s_rdata = 32'hBBBB_0001;
    sample(-1);
    tick();
    sample(-1);
    tick();

    // Lock dropped by its master releases the grant
    idle_inputs();
    m0_req = 1'b1;
    sample(-1);
    tick();
    m0_req = 1'b0;
    #1 chk("t4_s_req_drop", 128'(s_req), 128'(0));
    sample(-1);
    tick();
    m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1;
    #1 chk("t4_s_cmd_m1", 128'(s_cmd), 128'(m1_cmd));
    sample(1);
    tick();
    m1_req = 1'b0;
    sample(0);
    tick();
    idle_inputs();
    s_data_ok = 1'b1;
    sample(-1);
    tick();
    sample(-1);
    tick();

    // Full: 4 accepts, then s_req low even with a same-cycle response
    idle_inputs();
    m1_req = 1'b1; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(1);
      tick();
    end
    s_data_ok = 1'b1; s_rdata = 32'hCCCC_0000;
    #1 chk("t5_s_req_full", 128'(s_req), 128'(0));
    sample(-1);
    tick();
    s_data_ok = 1'b0; s_addr_ok = 1'b0;
    #1 chk("t5_s_req_back", 128'(s_req), 128'(1));
    sample(-1);
    tick();
    m1_req = 1'b0;
    #1 chk("t5_s_req_dropped", 128'(s_req), 128'(0));
    sample(-1);
    tick();
    s_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_rdata = $urandom;
      sample(-1);
      tick();
    end

    // Interleaved m1, m0, m1 accepts with in-order returns, wrapping pointers
    for (int r = 0; r < 10; r++) begin
      idle_inputs();
      s_addr_ok = 1'b1;
      m1_req = 1'b1;
      sample(1);
      tick();
      m1_req = 1'b0; m0_req = 1'b1;
      sample(0);
      tick();
      m0_req = 1'b0; m1_req = 1'b1;
      sample(1);
      tick();
      idle_inputs();
      s_data_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
        s_rdata = $urandom;
        sample(-1);
        tick();
      end
    end

    // Reset with requests in flight, then a late response flags arb_err
    idle_inputs();
    s_addr_ok = 1'b1; m0_req = 1'b1;
    sample(0);
    tick();
    m0_req = 1'b0; m1_req = 1'b1;
    sample(1);
    tick();
    resetn = 1'b0; m0_req = 1'b1; s_data_ok = 1'b1;
    #2 chk("rst2_s_req", 128'(s_req), 128'(0));
    chk("rst2_m1_addr_ok", 128'(m1_addr_ok), 128'(0));
    chk("rst2_m0_data_ok", 128'(m0_data_ok), 128'(0));
    chk("rst2_m1_data_ok", 128'(m1_data_ok), 128'(0));
    tick();
    idle_inputs();
    resetn = 1'b1;
    exp_q.delete();
    err_m = 1'b0;
    sample(-1);
    tick();
    s_data_ok = 1'b1;
    sample(-1);
    tick();
    s_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(-1);
      tick();
    end
    chk("t7_err_sticky", 128'(arb_err), 128'(1));
    m0_req = 1'b1; s_addr_ok = 1'b1;
    sample(0);
    tick();
    idle_inputs();
    s_data_ok = 1'b1; s_rdata = 32'hDDDD_0001;
    sample(-1);
    tick();
    idle_inputs();
    sample(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-master, one-slave arbiter for the CPU's SRAM-like request/addr_ok/data_ok bus. It merges the instruction-fetch port (master 0) and the data load/store port (master 1) onto a single memory-side port. It sits between the pipeline stages and the AXI bridge / cache refill path. It keeps an in-order FIFO of granted-master IDs so each data_ok/rdata pulse is returned to the master that issued the matching request.

## Interface
Parameters:
- OUTSTANDING, default 4: maximum accepted-but-unanswered requests; FIFO depth; must be a power of two ≥ 2.
- CMD_W, default 71: command bundle width, {wr[70], size[69:68], wstrb[67:64], addr[63:32], wdata[31:0]}.

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_req  in  1  instruction-fetch request
- m0_cmd  in  CMD_W  instruction-fetch command bundle
- m0_addr_ok  out  1  master 0 request accepted this cycle
- m0_data_ok  out  1  master 0 response valid this cycle
- m0_rdata  out  32  master 0 read data
- m1_req  in  1  data-port request
- m1_cmd  in  CMD_W  data-port command bundle
- m1_addr_ok  out  1  master 1 request accepted this cycle
- m1_data_ok  out  1  master 1 response valid this cycle
- m1_rdata  out  32  master 1 read data
- s_req  out  1  request to memory side
- s_cmd  out  CMD_W  command to memory side (the granted master's m*_cmd)
- s_addr_ok  in  1  memory side accepted s_req
- s_data_ok  in  1  memory side response; responses arrive in request order
- s_rdata  in  32  response data
- arb_err  out  1  sticky flag: s_data_ok arrived with the ID FIFO empty

## Operation
- Grant selection with no lock held: m1 wins over m0 when both request, because the data port belongs to an older instruction. m0 is granted only when m1_req=0.
- Lock: if s_req=1 and s_addr_ok=0 at a clock edge, the arbiter registers lock=1 and lock_id=granted master. While lock=1, the grant is forced to lock_id even if the other master raises req. The lock clears on the cycle s_addr_ok=1. The locked master must keep req and cmd stable until addr_ok, as the SRAM-like protocol requires.
- Lock dropped by master: if the locked master deasserts req, s_req drops and the lock clears at the next edge.
- s_req = (m0_req|m1_req, or locked master's req) & ~full. s_cmd = granted master's cmd.
- Acceptance: m{g}_addr_ok = s_addr_ok & s_req & (grant==g); the non-granted master's addr_ok is 0.
- ID FIFO: on acceptance, push g (1 bit). On s_data_ok with the FIFO non-empty, pop the head ID h, drive m{h}_data_ok=1, and drive m{h}_rdata=s_rdata. The other master's data_ok is 0. Both rdata outputs are always s_rdata; only data_ok is qualified.
- Counter: count is clog2(OUTSTANDING)+1 bits. Read and write pointers are clog2(OUTSTANDING) bits and wrap naturally at OUTSTANDING.
- Full: full = (count==OUTSTANDING). When full, s_req=0, with no exception even if s_data_ok pops in the same cycle (no same-cycle bypass).
- Simultaneous push and pop with the FIFO non-full: count is unchanged, both pointers advance.
- Empty-response: s_data_ok with count==0 sets arb_err, does not move pointers, and drives both m*_data_ok to 0.
- Writes (wr=1) also expect a data_ok; they are tracked the same way as reads.

## Timing
- Zero added latency: addr_ok and data_ok are combinational pass-throughs of s_addr_ok and s_data_ok, qualified by the grant or FIFO head.
- A response may return in the cycle after acceptance. The FIFO write must be visible to the head read by then; same-cycle accept plus response is not legal from the slave.
- Reset (asynchronous, resetn=0): lock=0, lock_id=0, pointers=0, count=0, arb_err=0. All outputs are combinationally 0 except rdata, which follows s_rdata.
- Reset mid-operation: all in-flight IDs are discarded. Any late s_data_ok after release sets arb_err, since the system resets the memory side together with this block.
- Registers update only at the rising edge of clk.

## Structure
- Shared package (`head.h` defines): CMD field offsets (CMD_WR, CMD_SIZE, CMD_WSTRB, CMD_ADDR, CMD_WDATA), CMD_W, and the master IDs ID_INST=0, ID_DATA=1.
- One sub-module: sram_id_fifo (parameter DEPTH, 1-bit data, push/pop/full/empty/head).
- Grant logic and lock register live in the top level.

## Test plan
- Single m0 read: m0_req=1 with addr 0x1C000000, slave addr_ok in cycle 0, data_ok in cycle 2 with rdata 0x02800000 -> m0_addr_ok in cycle 0, m0_data_ok=1 in cycle 2 with rdata 0x02800000; m1_data_ok stays 0 throughout.
- Both request, slave stalls addr_ok 3 cycles -> m1 granted; s_cmd stays equal to m1_cmd for all 4 cycles; then m0 is granted in cycle 4.
- Lock hold: m0 granted alone and stalled; m1_req rises in cycle 1 -> grant stays m0 until s_addr_ok, then moves to m1.
- Full: 4 accepted requests with no data_ok -> count=4, s_req=0; a data_ok in that cycle still leaves s_req=0; s_req returns the next cycle.
- Interleaved order: accepts m1, m0, m1, then 3 data_ok pulses -> data_ok delivered to m1, m0, m1 in that order; pointer wraps correctly across 10 rounds.
- Spurious data_ok after reset -> arb_err=1 and stays 1; no m*_data_ok pulse is produced.
